// File: rtl/fft_frame_ctrl_if.sv
// Bundles the sample-in, core load/run/read and sample-out ports of the FFT frame controller.
// master = controller side, slave = source / core / sink side.
interface fft_frame_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic                 in_valid;
  logic signed [DW-1:0] data_real_in;
  logic signed [DW-1:0] data_imag_in;
  logic                 in_ready;

  logic                 ld_en;
  logic        [AW-1:0] ld_addr;
  logic signed [DW-1:0] ld_real;
  logic signed [DW-1:0] ld_imag;

  logic                 core_start;
  logic                 core_done;

  logic        [AW-1:0] rd_addr;
  logic signed [DW-1:0] rd_real;
  logic signed [DW-1:0] rd_imag;

  logic signed [DW-1:0] data_real_out;
  logic signed [DW-1:0] data_imag_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 all_fft_done;
  logic                 timeout_err;
  logic           [7:0] frame_cnt;

  modport master (
    input  in_valid, data_real_in, data_imag_in,
    input  core_done, rd_real, rd_imag, out_ready,
    output in_ready, ld_en, ld_addr, ld_real, ld_imag, core_start,
    output rd_addr, data_real_out, data_imag_out, out_valid, out_last,
    output all_fft_done, timeout_err, frame_cnt
  );

  modport slave (
    output in_valid, data_real_in, data_imag_in,
    output core_done, rd_real, rd_imag, out_ready,
    input  in_ready, ld_en, ld_addr, ld_real, ld_imag, core_start,
    input  rd_addr, data_real_out, data_imag_out, out_valid, out_last,
    input  all_fft_done, timeout_err, frame_cnt
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an FFT core: load N_POINTS samples, start the core, stream results out.
// Accept->ld_en 1 cycle, last accept->core_start 2, core_done->out_valid 1; out_ready=0 freezes the output beat.
module fft_frame_ctrl #(
  parameter int N_POINTS = 32,
  parameter int AW       = 5,
  parameter int DW       = 16,
  parameter int TIMEOUT  = 1023
) (
  input logic              clk,
  input logic              reset,
  fft_frame_ctrl_if.master bus
);
  localparam int            WW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic    [1:0] state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] rd_cnt;
  logic [WW-1:0] wd_cnt;
  logic          err_q;
  logic    [7:0] frame_q;

  logic                 ld_en_q;
  logic        [AW-1:0] ld_addr_q;
  logic signed [DW-1:0] ld_real_q;
  logic signed [DW-1:0] ld_imag_q;
  logic                 start_q;
  logic                 done_q;

  logic accept;
  logic out_fire;

  // in_ready is gated by reset because IDLE would otherwise raise it while reset is held
  assign bus.in_ready      = ~reset & ((state == S_IDLE) | (state == S_LOAD));
  assign accept            = bus.in_valid & bus.in_ready;

  assign bus.out_valid     = (state == S_UNLOAD);
  assign bus.out_last      = bus.out_valid & (rd_cnt == LAST_IDX);
  assign out_fire          = bus.out_valid & bus.out_ready;

  assign bus.rd_addr       = rd_cnt;
  assign bus.data_real_out = bus.rd_real;
  assign bus.data_imag_out = bus.rd_imag;

  assign bus.ld_en         = ld_en_q;
  assign bus.ld_addr       = ld_addr_q;
  assign bus.ld_real       = ld_real_q;
  assign bus.ld_imag       = ld_imag_q;
  assign bus.core_start    = start_q;
  assign bus.all_fft_done  = done_q;
  assign bus.timeout_err   = err_q;
  assign bus.frame_cnt     = frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      rd_cnt   <= '0;
      wd_cnt   <= '0;
      err_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            load_cnt <= load_cnt + 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (load_cnt == LAST_IDX) begin
              load_cnt <= '0;
              wd_cnt   <= '0;
              state    <= S_RUN;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          // done wins over a timeout landing on the same cycle
          if (bus.core_done) begin
            rd_cnt <= '0;
            state  <= S_UNLOAD;
          end else if (wd_cnt == WD_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_UNLOAD: begin
          if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (bus.out_last) begin
              frame_q <= frame_q + 8'd1;
              state   <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_en_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_real_q <= '0;
      ld_imag_q <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ld_en_q <= accept;
      if (accept) begin
        ld_addr_q <= load_cnt;
        ld_real_q <= bus.data_real_in;
        ld_imag_q <= bus.data_imag_in;
      end
      // start follows the final write; suppressed if the core already answered
      start_q <= (state == S_RUN) & ld_en_q & (ld_addr_q == LAST_IDX) & ~bus.core_done;
      done_q  <= out_fire & bus.out_last;
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a behavioural FFT-core stand-in.
module tb_fft_frame_ctrl;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int TMO = 1023;

  logic clk;
  logic reset;

  fft_frame_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  fft_frame_ctrl #(.N_POINTS(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } beat_t;

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } ld_t;

  beat_t exp_q[$];
  ld_t   ld_q[$];

  // core stand-in: result[k] = sample[N-1-k] with real/imag swapped, done 10 cycles after start
  logic [DW-1:0] mem_re[N];
  logic [DW-1:0] mem_im[N];
  logic [DW-1:0] res_re[N];
  logic [DW-1:0] res_im[N];
  int            core_cnt;
  bit            core_en    = 1'b1;
  logic          stray_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) core_cnt <= 0;
    else if (bus.core_start && core_en) core_cnt <= 10;
    else if (core_cnt > 0) core_cnt <= core_cnt - 1;
  end

  always @(posedge clk) begin
    if (bus.ld_en) begin
      mem_re[bus.ld_addr] <= bus.ld_real;
      mem_im[bus.ld_addr] <= bus.ld_imag;
    end
    if (bus.core_start) begin
      for (int k = 0; k < N; k++) begin
        res_re[k] <= mem_im[N-1-k];
        res_im[k] <= mem_re[N-1-k];
      end
    end
  end

  assign bus.core_done = (core_cnt == 1) | stray_done;
  assign bus.rd_real   = res_re[bus.rd_addr];
  assign bus.rd_imag   = res_im[bus.rd_addr];

  bit rdy_rand = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? ($urandom_range(1) == 1) : 1'b1;
    end
  end

  // monitor
  int            n_start = 0, n_afd = 0;
  int            start_cyc = 0, done_cyc = 0, ov_rise_cyc = 0, err_cyc = 0;
  int            first_beat_cyc = 0, last_beat_cyc = 0;
  bit            ov_prev = 0, hold_prev = 0, err_prev = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_re, held_im;
  ld_t           le;
  beat_t         be;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        ov_prev   = 0;
        hold_prev = 0;
        err_prev  = 0;
      end else begin
        if (bus.ld_en) begin
          if (ld_q.size() == 0) check("ld_unexpected", 1, 0);
          else begin
            le = ld_q.pop_front();
            check("ld_cycle", cyc, le.cyc);
            check("ld_addr", bus.ld_addr, le.idx);
            check("ld_data", {bus.ld_real, bus.ld_imag}, {le.re, le.im});
          end
        end
        if (bus.core_start) begin
          n_start++;
          start_cyc = cyc;
        end
        if (bus.core_done && !stray_done) done_cyc = cyc;
        if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
        if (hold_prev && bus.out_valid)
          check("hold_stable", {bus.rd_addr, bus.data_real_out, bus.data_imag_out},
                {held_addr, held_re, held_im});
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("out_unexpected", 1, 0);
          else begin
            be = exp_q.pop_front();
            check("out_addr", bus.rd_addr, be.idx);
            check("out_data", {bus.data_real_out, bus.data_imag_out}, {be.re, be.im});
            check("out_last", bus.out_last, be.last);
            if (be.idx == 0) first_beat_cyc = cyc;
            if (be.last) last_beat_cyc = cyc;
          end
        end
        if (bus.all_fft_done) n_afd++;
        if (bus.timeout_err && !err_prev) err_cyc = cyc;
        ov_prev   = bus.out_valid;
        err_prev  = bus.timeout_err;
        hold_prev = bus.out_valid && !bus.out_ready;
        held_addr = bus.rd_addr;
        held_re   = bus.data_real_out;
        held_im   = bus.data_imag_out;
      end
    end
  end

  int last_acc = 0;

  // drives n samples of a frame; expected outputs are queued up front when push is set
  task automatic load_frame(input int n, input int gap, input bit sq, input bit push, input int stray_idx);
    logic [DW-1:0] s_re[N];
    logic [DW-1:0] s_im[N];
    int i = 0;
    int tries = 0;
    for (int k = 0; k < N; k++) begin
      if (sq) begin
        s_re[k] = ((k % 16) < 8) ? 16'h007f : 16'hff81;
        s_im[k] = '0;
      end else begin
        s_re[k] = DW'($urandom);
        s_im[k] = DW'($urandom);
      end
    end
    if (push)
      for (int k = 0; k < N; k++)
        exp_q.push_back('{idx: k, re: s_im[N-1-k], im: s_re[N-1-k], last: (k == N-1)});
    while (i < n && tries < 5000) begin
      @(negedge clk);
      tries++;
      bus.in_valid     = ($urandom_range(99) >= gap);
      bus.data_real_in = s_re[i];
      bus.data_imag_in = s_im[i];
      stray_done       = (i == stray_idx);
      if (bus.in_valid && bus.in_ready) begin
        ld_q.push_back('{cyc: cyc + 1, idx: i, re: s_re[i], im: s_im[i]});
        last_acc = cyc;
        i++;
      end
    end
    if (i < n) check("load_stall", i, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    stray_done   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while (bus.frame_cnt != 8'(target) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(name, bus.frame_cnt, target);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ctrl"}, {bus.in_ready, bus.ld_en, bus.core_start, bus.out_valid,
                           bus.out_last, bus.all_fft_done}, 0);
    check({tag, "_addr"}, {bus.ld_addr, bus.rd_addr}, 0);
    check({tag, "_data"}, {bus.ld_real, bus.ld_imag}, 0);
    check({tag, "_cnt"},  {bus.frame_cnt, bus.timeout_err}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "global timeout");
  end

  int afd0, t;

  initial begin
    bus.in_valid     = 1'b0;
    bus.data_real_in = '0;
    bus.data_imag_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("reset_init");
    @(posedge clk);
    #2 reset = 1'b0;

    // square wave, continuous valid, out_ready held high
    load_frame(N, 0, 1'b1, 1'b1, -1);
    check("in_ready_run", bus.in_ready, 0);
    wait_frames(1, "frame_cnt_sq");
    check("start_latency", start_cyc - last_acc, 2);
    check("done_to_valid", ov_rise_cyc - done_cyc, 1);
    check("beats_back_to_back", last_beat_cyc - first_beat_cyc, N - 1);
    check("core_start_count", n_start, 1);
    check("all_done_pulses", n_afd, 1);

    // stray done in IDLE, then again mid-LOAD
    @(posedge clk);
    #2 stray_done = 1'b1;
    @(posedge clk);
    #2 stray_done = 1'b0;
    @(negedge clk);
    check("stray_idle_state", {bus.in_ready, bus.out_valid, bus.ld_en}, 3'b100);
    load_frame(N, 0, 1'b0, 1'b1, 5);
    wait_frames(2, "frame_cnt_stray");
    check("start_latency_stray", start_cyc - last_acc, 2);
    check("core_start_count2", n_start, 2);

    // backpressure, gaps, back-to-back frames
    rdy_rand = 1'b1;
    load_frame(N, 30, 1'b0, 1'b1, -1);
    load_frame(N, 30, 1'b0, 1'b1, -1);
    load_frame(N, 30, 1'b0, 1'b1, -1);
    wait_frames(5, "frame_cnt_bp");
    check("all_done_pulses_bp", n_afd, 5);
    rdy_rand = 1'b0;

    // watchdog: core never answers
    core_en = 1'b0;
    afd0 = n_afd;
    load_frame(N, 0, 1'b0, 1'b0, -1);
    t = 0;
    while (!bus.timeout_err && t < TMO + 100) begin
      @(negedge clk);
      t++;
    end
    check("timeout_err_set", bus.timeout_err, 1);
    check("timeout_cycles", err_cyc - (last_acc + 1), TMO);
    check("timeout_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    repeat (3) @(negedge clk);
    check("timeout_no_done", n_afd, afd0);
    check("timeout_frame_cnt", bus.frame_cnt, 5);
    core_en = 1'b1;
    load_frame(N, 10, 1'b0, 1'b1, -1);
    wait_frames(6, "frame_cnt_after_to");
    check("timeout_sticky", bus.timeout_err, 1);

    // reset at load index 17
    load_frame(17, 0, 1'b0, 1'b0, -1);
    #2 reset = 1'b1;
    ld_q.delete();
    exp_q.delete();
    #1 reset_checks("reset_load");
    @(posedge clk);
    #2 reset = 1'b0;
    load_frame(N, 0, 1'b0, 1'b1, -1);
    wait_frames(1, "frame_cnt_after_rst1");

    // reset mid-UNLOAD
    rdy_rand = 1'b1;
    load_frame(N, 0, 1'b0, 1'b1, -1);
    t = 0;
    while (!(bus.out_valid && bus.rd_addr >= 5'd10) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reached_unload", bus.out_valid, 1);
    #2 reset = 1'b1;
    exp_q.delete();
    ld_q.delete();
    #1 reset_checks("reset_unload");
    @(posedge clk);
    #2 reset = 1'b0;
    rdy_rand = 1'b0;
    load_frame(N, 0, 1'b0, 1'b1, -1);
    wait_frames(1, "frame_cnt_after_rst2");

    check("exp_q_drained", exp_q.size(), 0);
    check("ld_q_drained", ld_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
